// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259-style PIC: init words, OCW writes, status reads and INTA cycles.
// Each bus cycle takes SETUP + STROBE_CYCLES + GAP_CYCLES clocks; losing requests are held by the host until served.
module pic_host_sequencer #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       cfg_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       irq,
  input  logic       ack_en,
  input  logic       wr_req,
  input  logic       wr_a0,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic       rd_a0,
  output logic       cs_neg,
  output logic       wr_neg,
  output logic       rd_neg,
  output logic       inta_neg,
  output logic       a0,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       wr_ack,
  output logic       cfg_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, GAP, INTA1, INTA_GAP, INTA2, DONE
  } state_t;

  localparam logic [3:0] STB_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            is_init_q, is_init_d;
  logic            is_rd_q, is_rd_d;
  logic [7:0]      hdat_q, hdat_d;
  logic            ha0_q, ha0_d;
  logic [3:0][7:0] words_q, words_d;
  logic            cfg_done_q, cfg_done_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            wr_ack_q, wr_ack_d;
  logic [7:0]      vector_q, vector_d;
  logic            vector_valid_q, vector_valid_d;

  logic [7:0] cur_dat;
  logic       cur_a0;
  logic       cyc_active;

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      is_init_q      <= 1'b0;
      is_rd_q        <= 1'b0;
      hdat_q         <= '0;
      ha0_q          <= 1'b0;
      words_q        <= '0;
      cfg_done_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      wr_ack_q       <= 1'b0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      is_init_q      <= is_init_d;
      is_rd_q        <= is_rd_d;
      hdat_q         <= hdat_d;
      ha0_q          <= ha0_d;
      words_q        <= words_d;
      cfg_done_q     <= cfg_done_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      wr_ack_q       <= wr_ack_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    is_init_d      = is_init_q;
    is_rd_d        = is_rd_q;
    hdat_d         = hdat_q;
    ha0_d          = ha0_q;
    words_d        = words_q;
    cfg_done_d     = cfg_done_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    wr_ack_d       = 1'b0;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Priority: init, interrupt acknowledge, host write, host read.
        if (cfg_start) begin
          words_d    = {ocw1, icw4, icw2, icw1};
          idx_d      = 2'd0;
          is_init_d  = 1'b1;
          is_rd_d    = 1'b0;
          cfg_done_d = 1'b0;
          state_d    = SETUP;
        end else if (irq && ack_en && cfg_done_q) begin
          cnt_d   = STB_LD;
          state_d = INTA1;
        end else if (wr_req) begin
          is_init_d = 1'b0;
          is_rd_d   = 1'b0;
          hdat_d    = wr_data;
          ha0_d     = wr_a0;
          state_d   = SETUP;
        end else if (rd_req) begin
          is_init_d = 1'b0;
          is_rd_d   = 1'b1;
          ha0_d     = rd_a0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = STB_LD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = GAP_LD;
          state_d = GAP;
          if (is_rd_q) begin
            rd_data_d  = bus_in;
            rd_valid_d = 1'b1;
          end else if (!is_init_q) begin
            wr_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          if (!is_init_q) begin
            state_d = IDLE;
          end else if (idx_q == 2'd3) begin
            cfg_done_d = 1'b1;
            state_d    = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      INTA1: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = GAP_LD;
          state_d = INTA_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      INTA_GAP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STB_LD;
          state_d = INTA2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      INTA2: begin
        // The sequence runs to completion regardless of irq/ack_en once started.
        if (cnt_q == 4'd0) begin
          vector_d       = bus_in;
          vector_valid_d = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        is_init_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cur_dat    = is_init_q ? words_q[idx_q] : hdat_q;
  assign cur_a0     = is_init_q ? (idx_q != 2'd0) : ha0_q;
  assign cyc_active = (state_q == SETUP) || (state_q == STROBE);

  assign cs_neg       = !cyc_active;
  assign wr_neg       = !((state_q == STROBE) && !is_rd_q);
  assign rd_neg       = !((state_q == STROBE) && is_rd_q);
  assign inta_neg     = !((state_q == INTA1) || (state_q == INTA2));
  assign a0           = cyc_active ? cur_a0 : 1'b0;
  assign bus_oe       = cyc_active && !is_rd_q;
  assign bus_out      = bus_oe ? cur_dat : 8'h00;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign wr_ack       = wr_ack_q;
  assign cfg_done     = cfg_done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Randomized scoreboard bench for pic_host_sequencer with a PIC-like bus responder.
module tb_pic_host_sequencer;
  localparam int STB = 2;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst_neg;
  logic       cfg_start;
  logic [7:0] icw1, icw2, icw4, ocw1;
  logic       irq, ack_en;
  logic       wr_req, wr_a0;
  logic [7:0] wr_data;
  logic       rd_req, rd_a0;
  logic       cs_neg, wr_neg, rd_neg, inta_neg, a0;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] rd_data;
  logic       rd_valid, wr_ack, cfg_done, busy;

  always #5 clk = ~clk;

  pic_host_sequencer #(.STROBE_CYCLES(STB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_neg(rst_neg), .cfg_start(cfg_start),
    .icw1(icw1), .icw2(icw2), .icw4(icw4), .ocw1(ocw1),
    .irq(irq), .ack_en(ack_en),
    .wr_req(wr_req), .wr_a0(wr_a0), .wr_data(wr_data),
    .rd_req(rd_req), .rd_a0(rd_a0),
    .cs_neg(cs_neg), .wr_neg(wr_neg), .rd_neg(rd_neg), .inta_neg(inta_neg), .a0(a0),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .vector(vector), .vector_valid(vector_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_ack(wr_ack),
    .cfg_done(cfg_done), .busy(busy)
  );

  // PIC responder: data is only correct during the final strobe clock.
  logic [7:0] rd_byte, vec_byte;
  int rd_run = 0, in_run = 0;
  always @(posedge clk) begin
    rd_run <= rd_neg ? 0 : rd_run + 1;
    in_run <= inta_neg ? 0 : in_run + 1;
  end
  assign bus_in = !rd_neg   ? ((rd_run == STB - 1) ? rd_byte : ~rd_byte) :
                  !inta_neg ? ((in_run == STB - 1) ? vec_byte : ~vec_byte) : 8'h00;

  typedef struct packed {
    logic [1:0] kind;  // 0 write, 1 read, 2 first INTA, 3 second INTA
    logic       a0;
    logic [7:0] dat;
  } bev_t;

  bev_t       exp_bus[$];
  logic [7:0] exp_vec[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_ack[$];

  int tests = 0;
  int fails = 0;
  bit drop_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic failnow(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event occurred with nothing expected", nm);
  endtask

  // Reference model: one expected bus transaction per request, in arbitration order.
  task automatic m_write(input logic a, input logic [7:0] d, input bit host);
    exp_bus.push_back({2'd0, a, d});
    if (host) exp_ack.push_back(d);
  endtask
  task automatic m_read(input logic a, input logic [7:0] d);
    exp_bus.push_back({2'd1, a, 8'h00});
    exp_rd.push_back(d);
  endtask
  task automatic m_ack(input logic [7:0] v);
    exp_bus.push_back({2'd2, 1'b0, 8'h00});
    exp_bus.push_back({2'd3, 1'b0, 8'h00});
    exp_vec.push_back(v);
  endtask
  task automatic flush_model();
    exp_bus.delete(); exp_vec.delete(); exp_rd.delete(); exp_ack.delete();
  endtask

  // Monitor
  logic p_wr = 1'b1, p_rd = 1'b1, p_in = 1'b1, p_vv = 1'b0, p_rv = 1'b0, p_ak = 1'b0;
  int wr_lo = 0, rd_lo = 0, in_lo = 0, in_hi = 0;

  task automatic bus_evt(input int kact);
    bev_t e;
    if (exp_bus.size() == 0) begin
      failnow($sformatf("unexpected_bus_cycle_kind%0d", kact));
    end else begin
      e = exp_bus.pop_front();
      if (kact == 2) begin
        chk("bus_kind_inta", e.kind[1], 1'b1);
        if (e.kind == 2'd3) chk("inta_gap_width", in_hi, GAP);
      end else begin
        chk("bus_kind", e.kind, kact);
        chk("a0", a0, e.a0);
        chk("cs_low", cs_neg, 1'b0);
        chk("bus_oe", bus_oe, (kact == 0));
        if (kact == 0) chk("bus_out", bus_out, e.dat);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_neg) begin
      p_wr = 1'b1; p_rd = 1'b1; p_in = 1'b1;
      p_vv = 1'b0; p_rv = 1'b0; p_ak = 1'b0;
      wr_lo = 0; rd_lo = 0; in_lo = 0; in_hi = 0;
    end else begin
      if (!(wr_neg && rd_neg && inta_neg))
        chk("one_strobe", ($countones({~wr_neg, ~rd_neg, ~inta_neg}) <= 1), 1'b1);
      if (!inta_neg) chk("inta_cs_high", cs_neg, 1'b1);

      if (!wr_neg) begin
        if (p_wr) bus_evt(0);
        wr_lo++;
      end else if (!p_wr) begin
        chk("wr_width", wr_lo, STB);
        wr_lo = 0;
      end
      if (!rd_neg) begin
        if (p_rd) bus_evt(1);
        rd_lo++;
      end else if (!p_rd) begin
        chk("rd_width", rd_lo, STB);
        rd_lo = 0;
      end
      if (!inta_neg) begin
        if (p_in) bus_evt(2);
        in_lo++;
        in_hi = 0;
      end else begin
        if (!p_in) begin
          chk("inta_width", in_lo, STB);
          in_lo = 0;
        end
        in_hi++;
      end

      if (vector_valid) begin
        if (exp_vec.size() == 0) failnow("vector_valid");
        else chk("vector", vector, exp_vec.pop_front());
        chk("vector_valid_pulse", p_vv, 1'b0);
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) failnow("rd_valid");
        else chk("rd_data", rd_data, exp_rd.pop_front());
        chk("rd_valid_pulse", p_rv, 1'b0);
      end
      if (wr_ack) begin
        if (exp_ack.size() == 0) failnow("wr_ack");
        else void'(exp_ack.pop_front());
        chk("wr_ack_pulse", p_ak, 1'b0);
      end

      p_wr = wr_neg; p_rd = rd_neg; p_in = inta_neg;
      p_vv = vector_valid; p_rv = rd_valid; p_ak = wr_ack;
    end
  end

  function automatic bit model_empty();
    return (exp_bus.size() == 0) && (exp_vec.size() == 0) &&
           (exp_rd.size() == 0) && (exp_ack.size() == 0);
  endfunction

  // Host/PIC driver: drop each request once the DUT shows it is served.
  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (!inta_neg) begin
        irq = 1'b0;
        if (drop_en) ack_en = 1'b0;
      end
      if (wr_ack)   wr_req = 1'b0;
      if (rd_valid) rd_req = 1'b0;
      if (!irq && !wr_req && !rd_req && !busy && model_empty()) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d bus events still pending, required 0", exp_bus.size());
      flush_model();
      irq = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    end
  endtask

  task automatic start_init(input logic [7:0] w1, w2, w4, o1, input bit timing);
    m_write(1'b0, w1, 1'b0);
    m_write(1'b1, w2, 1'b0);
    m_write(1'b1, w4, 1'b0);
    m_write(1'b1, o1, 1'b0);
    @(negedge clk);
    icw1 = w1; icw2 = w2; icw4 = w4; ocw1 = o1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("cfg_done_clear_on_accept", cfg_done, 1'b0);
    if (timing) begin
      repeat (15) @(negedge clk);
      chk("cfg_done_clk15", cfg_done, 1'b0);
      @(negedge clk);
      chk("cfg_done_clk16", cfg_done, 1'b1);
    end
  endtask

  logic [34:0] rst_exp, rst_act;
  int seen;
  int mask;

  initial begin
    rst_neg = 1'b0; cfg_start = 1'b0;
    icw1 = 8'h00; icw2 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00;
    irq = 1'b0; ack_en = 1'b0;
    wr_req = 1'b0; wr_a0 = 1'b0; wr_data = 8'h00;
    rd_req = 1'b0; rd_a0 = 1'b0;
    rd_byte = 8'h00; vec_byte = 8'h00;
    rst_exp = {4'b1111, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst_act = {cs_neg, wr_neg, rd_neg, inta_neg, a0, bus_oe, bus_out, busy, cfg_done,
               vector, vector_valid, rd_data, rd_valid, wr_ack};
    chk("reset_outputs", rst_act, rst_exp);
    rst_neg = 1'b1;

    // Interrupt pending before init must not be acknowledged.
    @(negedge clk);
    irq = 1'b1; ack_en = 1'b1; vec_byte = 8'h15;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (!inta_neg) seen++;
    end
    chk("no_ack_before_cfg_done", seen, 0);

    start_init(8'hC8, 8'h15, 8'hC0, 8'h40, 1'b1);
    m_ack(8'h15);
    drain(200);

    // Simultaneous ack, write and read: served in priority order.
    @(negedge clk);
    vec_byte = 8'($urandom);
    rd_byte  = 8'hE0;
    m_ack(vec_byte);
    m_write(1'b0, 8'h01, 1'b1);
    m_read(1'b1, 8'hE0);
    irq = 1'b1;
    wr_req = 1'b1; wr_a0 = 1'b0; wr_data = 8'h01;
    rd_req = 1'b1; rd_a0 = 1'b1;
    drain(200);

    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      mask     = int'($urandom_range(1, 7));
      drop_en  = 1'($urandom_range(0, 1));
      ack_en   = 1'b1;
      vec_byte = 8'($urandom);
      rd_byte  = 8'($urandom);
      wr_data  = 8'($urandom);
      wr_a0    = 1'($urandom);
      rd_a0    = 1'($urandom);
      if (mask[0]) m_ack(vec_byte);
      if (mask[1]) m_write(wr_a0, wr_data, 1'b1);
      if (mask[2]) m_read(rd_a0, rd_byte);
      irq    = mask[0];
      wr_req = mask[1];
      rd_req = mask[2];
      drain(200);
    end
    drop_en = 1'b0;
    ack_en  = 1'b1;

    start_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    drain(100);

    // Reset during the strobe of the second init word.
    start_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    seen = 0;
    while (exp_bus.size() > 2 && seen < 40) begin
      @(negedge clk);
      #1;
      seen++;
    end
    chk("icw2_strobe_reached", (exp_bus.size() == 2) && !wr_neg, 1'b1);
    rst_neg = 1'b0;
    #1;
    chk("rst_wr_neg", wr_neg, 1'b1);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    flush_model();
    wr_data = 8'($urandom);
    wr_a0   = 1'($urandom);
    m_write(wr_a0, wr_data, 1'b1);
    wr_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_neg = 1'b1;
    @(negedge clk);
    chk("arb_first_clock_after_rst", {busy, cs_neg}, 2'b10);
    drain(100);
    repeat (20) @(negedge clk);
    chk("no_init_resume_cfg_done", cfg_done, 1'b0);

    chk("queues_empty", exp_bus.size() + exp_vec.size() + exp_rd.size() + exp_ack.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, SHALL set clocks each active-low strobe (wr_neg, rd_neg, inta_neg) is held low; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 1, SHALL set recovery clocks with all strobes high after each strobe; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_neg  input  1  asynchronous, active-low reset.
REQ-005 cfg_start  input  1  one-cycle request to run the init sequence.
REQ-006 icw1, icw2, icw4, ocw1  input  8 each  init words, sampled when cfg_start is accepted.
REQ-007 irq  input  1  PIC interrupt_flag, level, already synchronous to clk.
REQ-008 ack_en  input  1  host permits acknowledge cycles when high.
REQ-009 wr_req / wr_a0 / wr_data  input  1/1/8  host OCW write request, address bit, data.
REQ-010 rd_req / rd_a0  input  1/1  host status-read request (IRR/ISR/IMR per last OCW3).
REQ-011 cs_neg, wr_neg, rd_neg, inta_neg, a0  output  1 each  PIC bus control.
REQ-012 bus_out / bus_oe  output  8/1  write data and its drive enable; bus_in  input  8  data from PIC.
REQ-013 vector / vector_valid  output  8/1  captured interrupt vector, one-cycle strobe.
REQ-014 rd_data / rd_valid  output  8/1  status byte, one-cycle strobe; wr_ack output 1 one-cycle strobe.
REQ-015 cfg_done  output  1  init complete; busy  output  1  any bus cycle in progress.

Function
REQ-016 States SHALL be IDLE, SETUP, STROBE, GAP, INTA1, INTA_GAP, INTA2, DONE; a 2-bit init index (0..3) and a 4-bit phase counter SHALL sequence them.
REQ-017 Arbitration in IDLE, highest first: cfg_start; interrupt ack (irq & ack_en & cfg_done); wr_req; rd_req; losers SHALL hold their request and are served later.
REQ-018 Write cycle: SETUP 1 clock (cs_neg=0, a0, bus_out, bus_oe=1, strobes high); STROBE STROBE_CYCLES clocks wr_neg=0; GAP GAP_CYCLES clocks wr_neg=1, bus_oe=0, cs_neg=1; then IDLE.
REQ-019 Read cycle: as REQ-018 with rd_neg instead of wr_neg and bus_oe=0 throughout; bus_in SHALL be sampled on the last STROBE clock into rd_data, rd_valid pulsing on the first GAP clock.
REQ-020 Init sequence SHALL issue four back-to-back write cycles: icw1 a0=0, icw2 a0=1, icw4 a0=1, ocw1 a0=1; cfg_done SHALL rise in the clock after the final GAP ends and remain high until reset or next cfg_start.
REQ-021 cfg_start SHALL clear cfg_done at acceptance; cfg_start while busy SHALL be ignored.
REQ-022 Ack sequence: INTA1 inta_neg=0 STROBE_CYCLES, INTA_GAP high GAP_CYCLES, INTA2 low STROBE_CYCLES; cs_neg SHALL stay 1; bus_in sampled on last INTA2 clock; vector_valid pulses on the following clock.
REQ-023 Once INTA1 starts, the ack sequence SHALL complete even if irq drops or ack_en falls; the captured byte is reported unmodified.
REQ-024 wr_ack SHALL pulse on the first GAP clock of a host write; never during init.
REQ-025 busy SHALL be 1 in every state except IDLE; at most one strobe low in any clock.
REQ-026 Phase counter SHALL count down from parameter-1 to 0 and reload; no wrap beyond range.

Reset
REQ-027 rst_neg low SHALL immediately force cs_neg, wr_neg, rd_neg, inta_neg = 1, bus_oe=0, a0=0, bus_out=0, state IDLE, cfg_done=0, busy=0, vector=0, rd_data=0, all strobes/valids 0.
REQ-028 Reset asserted mid-cycle SHALL abort it with no valid/ack pulse; requests present at deassertion are arbitrated from IDLE on the first clock.

Verification
REQ-029 Init: cfg_start with icw1=0xC8, icw2=0x15, icw4=0xC0, ocw1=0x40 -> four wr_neg pulses 2 clocks wide, a0 sequence 0,1,1,1, bus_out matches, cfg_done at clock 16 after acceptance.
REQ-030 Ack: after init, irq=1, ack_en=1, bus_in=0x15 -> inta_neg low 2, high 1, low 2; vector=0x15, vector_valid one clock; cs_neg never low.
REQ-031 Arbitration: irq, wr_req(0x01,a0=0) and rd_req same clock in IDLE -> ack first, then write (wr_ack), then read (rd_valid with bus_in=0xE0 -> rd_data=0xE0).
REQ-032 irq dropped after INTA1 -> INTA2 still issued, vector_valid pulses.
REQ-033 irq=1 before cfg_done -> no inta_neg activity until cfg_done=1.
REQ-034 rst_neg low during STROBE of icw2 -> wr_neg=1 same instant, cfg_done=0, no further writes until new cfg_start.
